// File: rtl/asyn_sched_b_if.sv
// Scheduler bus: requester handshakes plus the shared-engine control lines.
// The master side (requesters + engine) drives req_i, eng_done and clr_err;
// the scheduler (slave side) drives everything else.
interface asyn_sched_b_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] ack_o;
  logic               eng_start;
  logic [ID_W-1:0]    eng_sel;
  logic               eng_done;
  logic               busy;
  logic               err_timeout;
  logic               clr_err;

  modport master (
    output req_i, eng_done, clr_err,
    input  ack_o, eng_start, eng_sel, busy, err_timeout
  );

  modport slave (
    input  req_i, eng_done, clr_err,
    output ack_o, eng_start, eng_sel, busy, err_timeout
  );
endinterface

// File: rtl/asyn_sched_b.sv
// asyn_sched_b: clock-B scheduler sharing one compute engine between NUM_REQ
// 4-phase requesters. One job in flight, watchdog on engine completion,
// sticky timeout flag. Arbitration is round-robin by default; defining
// ASYN_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority and removes
// the round-robin pointer.
module asyn_sched_b #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input logic           clk_B,
  input logic           rst_B,
  asyn_sched_b_if.slave bus
);
  localparam int PAD_W = 2**ID_W;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [PAD_W-1:0]   elig_pad;
  logic [PAD_W-1:0]   sel_oh;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    idx;
  logic               any_elig;
  logic               done_ok;
  logic               tmo_hit;
  logic               finish;
  logic               tmo_err;
  logic [NUM_REQ-1:0] ack_set;
`ifndef ASYN_SCHED_FIXED_PRIO_EN
  logic [ID_W-1:0]    ptr;
`endif

  // Eligibility and one-hot of the served index, padded to 2**ID_W so that
  // ID_W-wide indices always land inside the vector.
  always_comb begin
    elig_pad = PAD_W'(bus.req_i & ~bus.ack_o);
    sel_oh   = '0;
    sel_oh[bus.eng_sel] = 1'b1;
  end

  // Winner search: first eligible index upward from the pointer (or from 0).
  always_comb begin
    winner   = '0;
    any_elig = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef ASYN_SCHED_FIXED_PRIO_EN
      idx = ID_W'(k);
`else
      idx = ID_W'((32'(ptr) + k) % 32'(NUM_REQ));
`endif
      if (!any_elig && elig_pad[idx]) begin
        any_elig = 1'b1;
        winner   = idx;
      end
    end
  end

  // Job completion: eng_done (not in the start cycle) or watchdog expiry.
  // A done pulse in the expiry cycle counts as a normal completion.
  always_comb begin
    done_ok = (state == RUN) && !bus.eng_start && bus.eng_done;
    tmo_hit = (state == RUN) && (count == CNT_W'(TIMEOUT_CYC));
    finish  = done_ok || tmo_hit;
    tmo_err = tmo_hit && !done_ok;
    ack_set = finish ? (NUM_REQ'(sel_oh) & bus.req_i) : '0;
  end

  // Scheduler FSM: IDLE arbitrates, RUN waits for completion or timeout.
  always_ff @(posedge clk_B) begin
    if (rst_B) begin
      state         <= IDLE;
      bus.eng_start <= 1'b0;
      bus.eng_sel   <= '0;
      bus.busy      <= 1'b0;
      count         <= '0;
`ifndef ASYN_SCHED_FIXED_PRIO_EN
      ptr           <= '0;
`endif
    end else begin
      bus.eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (any_elig) begin
            state         <= RUN;
            bus.eng_start <= 1'b1;
            bus.eng_sel   <= winner;
            bus.busy      <= 1'b1;
            count         <= '0;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (finish) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
`ifndef ASYN_SCHED_FIXED_PRIO_EN
            ptr      <= (bus.eng_sel == ID_W'(NUM_REQ - 1)) ? '0 : bus.eng_sel + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Acks: set on completion while the request is still up, cleared once the
  // request is seen low; sticky timeout flag where set beats clear.
  always_ff @(posedge clk_B) begin
    if (rst_B) begin
      bus.ack_o       <= '0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.ack_o <= (bus.ack_o & bus.req_i) | ack_set;
      if (tmo_err)
        bus.err_timeout <= 1'b1;
      else if (bus.clr_err)
        bus.err_timeout <= 1'b0;
    end
  end
endmodule

// File: tb/tb_asyn_sched_b.sv
// Self-checking bench for asyn_sched_b: vector table of single jobs plus
// hand-written fairness, timeout, protocol-violation and reset sequences.
module tb_asyn_sched_b;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int TO = 8;

  logic clk_B = 1'b0;
  logic rst_B;

  asyn_sched_b_if #(.NUM_REQ(NR), .ID_W(IW)) bus ();

  asyn_sched_b #(
    .NUM_REQ(NR),
    .ID_W(IW),
    .TIMEOUT_CYC(TO),
    .CNT_W(8)
  ) dut (
    .clk_B(clk_B),
    .rst_B(rst_B),
    .bus(bus)
  );

  always #5 clk_B = ~clk_B;

  int total = 0;
  int bad   = 0;
  logic [IW-1:0] sb_q[$];

  typedef struct {
    logic [3:0] req;
    int         dly;
    logic [1:0] sel;
    logic [3:0] ack;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk_B);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Wait (bounded) for eng_start, then compare latency and the granted index
  // against the next scoreboard entry.
  task automatic wait_start(input int exp_lat);
    int n;
    logic [IW-1:0] e;
    n = 0;
    e = '0;
    while (bus.eng_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("start_lat", n, exp_lat);
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: got start sel %0d want none", bus.eng_sel);
    end else begin
      e = sb_q.pop_front();
      chk("eng_sel", bus.eng_sel, e);
    end
    chk("busy_start", bus.busy, 1);
  endtask

  // From the start cycle: pulse eng_done d cycles later, then check the
  // completion outputs one cycle after the pulse.
  task automatic finish_job(input int d, input logic [3:0] exp_ack, input logic exp_err);
    for (int i = 0; i < d; i++) begin
      tick();
      if (i == 0) chk("start_pulse", bus.eng_start, 0);
    end
    chk("busy_run", bus.busy, 1);
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    chk("busy_done", bus.busy, 0);
    chk("ack_done", bus.ack_o, exp_ack);
    chk("err_done", bus.err_timeout, exp_err);
  endtask

  initial begin
    int n;
    logic [1:0] e_first;

    vecs[0] = '{4'b0010, 5, 2'd1, 4'b0010};
    vecs[1] = '{4'b0011, 2, 2'd0, 4'b0001};
    vecs[2] = '{4'b1000, 3, 2'd3, 4'b1000};
    vecs[3] = '{4'b1111, 1, 2'd0, 4'b0001};
    vecs[4] = '{4'b1100, 4, 2'd2, 4'b0100};
    vecs[5] = '{4'b0101, 6, 2'd0, 4'b0001};
    vecs[6] = '{4'b0110, 7, 2'd1, 4'b0010};
`ifdef ASYN_SCHED_FIXED_PRIO_EN
    vecs[7] = '{4'b1001, TO, 2'd0, 4'b0001};
`else
    vecs[7] = '{4'b1001, TO, 2'd3, 4'b1000};
`endif

    bus.req_i    = '0;
    bus.eng_done = 1'b0;
    bus.clr_err  = 1'b0;
    rst_B        = 1'b1;
    repeat (3) tick();
    chk("rst_ack", bus.ack_o, 0);
    chk("rst_start", bus.eng_start, 0);
    chk("rst_sel", bus.eng_sel, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err_timeout, 0);
    rst_B = 1'b0;
    tick();

    // Vector table; the last entry puts eng_done in the watchdog expiry cycle.
    for (int i = 0; i < 8; i++) begin
      bus.req_i = vecs[i].req;
      sb_q.push_back(vecs[i].sel);
      wait_start(1);
      finish_job(vecs[i].dly, vecs[i].ack, 1'b0);
      bus.req_i = '0;
      tick();
      chk("ack_release", bus.ack_o, 0);
      chk("no_stray_start", bus.eng_start, 0);
    end

    // Fairness: all requesting, each drops after its ack.
    bus.req_i = 4'b1111;
    for (int k = 0; k < 4; k++) sb_q.push_back(2'(k));
    for (int k = 0; k < 4; k++) begin
      wait_start(1);
      finish_job(2, 4'(1 << k), 1'b0);
      bus.req_i[k] = 1'b0;
    end
    tick();
    chk("fair_ack_clear", bus.ack_o, 0);
    bus.req_i = 4'b1001;
    sb_q.push_back(2'd0);
    wait_start(1);
    finish_job(3, 4'b0001, 1'b0);
    bus.req_i = '0;
    tick();

    // Timeout with clr_err held: set wins, then late done ignored, then clear.
    bus.req_i = 4'b0010;
    sb_q.push_back(2'd1);
    wait_start(1);
    bus.clr_err = 1'b1;
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    bus.clr_err = 1'b0;
    chk("tmo_cycles", n, TO + 1);
    chk("tmo_ack", bus.ack_o, 4'b0010);
    chk("tmo_err", bus.err_timeout, 1);
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    tick();
    chk("late_busy", bus.busy, 0);
    chk("late_start", bus.eng_start, 0);
    chk("late_err", bus.err_timeout, 1);
    chk("late_ack", bus.ack_o, 4'b0010);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("clr_err", bus.err_timeout, 0);
    bus.req_i = '0;
    tick();

    // Requester 2 drops mid-RUN: no ack, requester 3 served next.
    bus.req_i = 4'b1100;
    sb_q.push_back(2'd2);
    sb_q.push_back(2'd3);
    wait_start(1);
    bus.req_i = 4'b1000;
    finish_job(4, 4'b0000, 1'b0);
    wait_start(1);
    finish_job(2, 4'b1000, 1'b0);
    bus.req_i = '0;
    tick();

    // Reset mid-RUN with a held request.
    bus.req_i = 4'b0010;
    sb_q.push_back(2'd1);
    wait_start(1);
    finish_job(2, 4'b0010, 1'b0);
    bus.req_i = '0;
    tick();
`ifdef ASYN_SCHED_FIXED_PRIO_EN
    e_first = 2'd1;
`else
    e_first = 2'd2;
`endif
    bus.req_i = 4'b0110;
    sb_q.push_back(e_first);
    wait_start(1);
    tick();
    tick();
    rst_B = 1'b1;
    tick();
    chk("mid_rst_ack", bus.ack_o, 0);
    chk("mid_rst_start", bus.eng_start, 0);
    chk("mid_rst_sel", bus.eng_sel, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_err", bus.err_timeout, 0);
    rst_B = 1'b0;
    sb_q.push_back(2'd1);
    wait_start(1);
    finish_job(3, 4'b0010, 1'b0);
    bus.req_i = '0;
    tick();
    chk("final_ack", bus.ack_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
